// File: rtl/sample_player.sv
// sample_player: buffers up to TOTAL_DATA samples, then replays them on start as a
// valid-qualified stream with a zero-based index, throttled by hold.
`default_nettype none

module sample_player #(
  parameter int O_BW       = 14,
  parameter int TOTAL_DATA = 15104,
  parameter int AW         = $clog2(TOTAL_DATA)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [O_BW-1:0] wr_data,
  input  logic            start,
  input  logic            hold,
  output logic            do_en,
  output logic [O_BW-1:0] data_o,
  output logic [AW-1:0]   num,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH   = (AW+1)'(TOTAL_DATA);
  localparam logic [AW:0]   WR_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] RD_ONE  = AW'(1);

  state_t          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            do_en_q, done_q;
  logic [O_BW-1:0] data_q;
  logic [AW-1:0]   num_q;
  logic            we, re, is_last;

  logic [O_BW-1:0] mem [TOTAL_DATA];

  // The address about to be issued is the final stored sample.
  assign is_last = ({1'b0, rd_ptr_q} == (wr_ptr_q - WR_ONE));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    re       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (wr_ptr_q != DEPTH) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + WR_ONE;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (start && (wr_ptr_q != '0)) begin
          state_d  = PLAY;
          rd_ptr_d = '0;
        end
      end
      PLAY: begin
        if (!hold) begin
          re       = 1'b1;
          rd_ptr_d = rd_ptr_q + RD_ONE;
          if (is_last) state_d = LAST;
        end
      end
      LAST: begin
        wr_ptr_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // RAM read register doubles as the output stage; it holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      do_en_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      num_q   <= '0;
    end else begin
      do_en_q <= re;
      done_q  <= re && is_last;
      if (re) begin
        data_q <= mem[rd_ptr_q];
        num_q  <= rd_ptr_q;
      end
    end
  end

  assign do_en  = do_en_q;
  assign done   = done_q;
  assign data_o = data_q;
  assign num    = num_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sample_player.sv
// Scoreboard bench for sample_player with an 8-deep buffer.
`default_nettype none

module tb_sample_player;

  localparam int O_BW = 14;
  localparam int TD   = 8;
  localparam int AW   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic [O_BW-1:0] wr_data = '0;
  logic            start = 1'b0;
  logic            hold = 1'b0;
  logic            do_en, busy, done, ovf;
  logic [O_BW-1:0] data_o;
  logic [AW-1:0]   num;

  sample_player #(.O_BW(O_BW), .TOTAL_DATA(TD), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .hold(hold), .do_en(do_en), .data_o(data_o), .num(num), .busy(busy),
    .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   num;
    logic [O_BW-1:0] data;
    logic            done;
  } exp_t;

  exp_t            sb[$];
  logic [O_BW-1:0] mdl[$];
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && do_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_do_en", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("num", 32'(num), 32'(e.num));
        chk("data_o", 32'(data_o), 32'(e.data));
        chk("done", 32'(done), 32'(e.done));
      end
    end else if (rst && done) begin
      chk("done_without_do_en", 32'(done), 32'd0);
    end
  end

  task automatic load(input logic [O_BW-1:0] v);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_data = v;
    if (mdl.size() < TD) mdl.push_back(v);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Pulse start, then step PLAY cycles predicting do_en from the hold pattern.
  task automatic play(input int n, input int hold_cyc, input bit expect_out, input bit noise);
    int issued;
    bit exp_en;
    issued = 0;
    exp_en = 1'b0;
    if (expect_out) begin
      for (int i = 0; i < n; i++) begin
        exp_t e;
        e.num = i[AW-1:0]; e.data = mdl[i]; e.done = (i == n - 1);
        sb.push_back(e);
      end
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < n + 4; c++) begin
      hold    = (c == hold_cyc);
      wr_en   = noise && (c < 3);
      wr_data = O_BW'($urandom);
      start   = noise && (c == 1);
      @(negedge clk);
      chk("do_en_pattern", 32'(do_en), 32'(exp_en));
      if (c == 0) chk("busy_after_start", 32'(busy), 32'(expect_out));
      exp_en = expect_out && !hold && (issued < n);
      if (exp_en) issued++;
      @(posedge clk); #1;
    end
    hold = 1'b0; wr_en = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("busy_end", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    if (expect_out) mdl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit seen;
    #12;
    chk("rst_do_en", 32'(do_en), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_num", 32'(num), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // basic 4-sample block
    load(14'h0011); load(14'h0022); load(14'h0033); load(14'h0044);
    play(4, -1, 1'b1, 1'b0);

    // hold on the second issue cycle
    load(14'h0011); load(14'h0022); load(14'h0033); load(14'h0044);
    play(4, 1, 1'b1, 1'b0);

    // hold on the would-be last issue
    load(14'h0101); load(14'h0202); load(14'h0303);
    play(3, 2, 1'b1, 1'b0);

    // empty start, then single sample
    play(0, -1, 1'b0, 1'b0);
    load(14'h3FFF);
    play(1, -1, 1'b1, 1'b0);

    // overflow: 10 writes into an 8-deep buffer
    for (int i = 0; i < 10; i++) begin
      load(O_BW'(16'h0100 + i));
      @(negedge clk);
      if (i == 7) chk("ovf_at_full", 32'(ovf), 32'd0);
      if (i == 8) chk("ovf_after_9th", 32'(ovf), 32'd1);
    end
    play(8, -1, 1'b1, 1'b0);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // writes and a second start during PLAY are ignored
    for (int i = 0; i < 4; i++) load(O_BW'($urandom));
    play(4, -1, 1'b1, 1'b1);

    // async reset mid-playback
    load(14'h0A01); load(14'h0A02); load(14'h0A03); load(14'h0A04);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.num = i[AW-1:0]; e.data = mdl[i]; e.done = (i == 3);
      sb.push_back(e);
    end
    mdl.delete();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (do_en && num == 3'd1) seen = 1'b1;
    end
    chk("reached_num1", 32'(seen), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_do_en", 32'(do_en), 32'd0);
    chk("midrst_data_o", 32'(data_o), 32'd0);
    chk("midrst_num", 32'(num), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b1;
    play(0, -1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
